// File: rtl/intt_sdf_stage.sv
// rtl/intt_sdf_stage.sv - inverse-NTT radix-2 SDF stage (twiddle multiply, then butterfly)
// Optional output scaling by N_INV is compiled in with `define INTT_SCALE_EN.
module intt_sdf_stage #(
  parameter int W        = 32,
  parameter int MODULUS  = 7681,
  parameter int DEPTH    = 4,
  parameter int TW_DEPTH = 8,
  parameter int TW_STEP  = TW_DEPTH / DEPTH,
  parameter int N_INV    = 6721,
  localparam int CW      = (DEPTH == 1) ? 1 : $clog2(2 * DEPTH),
  localparam int AW      = (TW_DEPTH <= 1) ? 1 : $clog2(TW_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic [AW-1:0] tw_addr,
  input  logic [W-1:0]  tw_data,
  output logic          out_valid,
  output logic [W-1:0]  out_data
);

  localparam logic [W-1:0]   MOD_W    = W'(MODULUS);
  localparam logic [2*W-1:0] MOD_2W   = (2*W)'(MODULUS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(2 * DEPTH - 1);

  logic [CW-1:0]  cnt;
  logic [AW-1:0]  tw_idx;
  logic           primed;
  logic           phase;
  logic [W-1:0]   dl [DEPTH];
  logic [W-1:0]   head;

  logic [2*W-1:0] prod;
  logic [W-1:0]   t;
  logic [W:0]     sum_raw;
  logic [W-1:0]   sum;
  logic [W-1:0]   diff;
  logic [W-1:0]   cand;
  logic [W-1:0]   cand_out;
  logic [W-1:0]   push_val;

  assign phase   = cnt[CW-1];
  assign head    = dl[DEPTH-1];
  assign tw_addr = tw_idx;

  // Butterfly on the twiddled sample against the first-half value waiting at the head
  assign prod    = {{W{1'b0}}, in_data} * {{W{1'b0}}, tw_data};
  assign t       = W'(prod % MOD_2W);
  assign sum_raw = {1'b0, head} + {1'b0, t};
  assign sum     = (sum_raw >= {1'b0, MOD_W}) ? W'(sum_raw - {1'b0, MOD_W}) : sum_raw[W-1:0];
  assign diff    = (head < t) ? (head - t + MOD_W) : (head - t);

  assign cand     = phase ? sum : head;
  assign push_val = phase ? diff : in_data;

`ifdef INTT_SCALE_EN
  localparam logic [W-1:0] N_INV_W = W'(N_INV);
  logic [2*W-1:0] scale_prod;
  assign scale_prod = {{W{1'b0}}, cand} * {{W{1'b0}}, N_INV_W};
  assign cand_out   = W'(scale_prod % MOD_2W);
`else
  // N_INV only matters when scaling is compiled in
  localparam logic [31:0] N_INV_BITS = N_INV;
  logic unused_n_inv;
  assign unused_n_inv = ^N_INV_BITS;
  assign cand_out     = cand;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      tw_idx <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        tw_idx <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (phase)
          tw_idx <= AW'((int'(tw_idx) + TW_STEP) % TW_DEPTH);
      end
      if (phase)
        primed <= 1'b1;
    end
  end

  // Delay line is deliberately left unreset; primed masks its stale contents
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl[0] <= push_val;
      for (int i = 1; i < DEPTH; i++)
        dl[i] <= dl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid & (primed | phase);
      if (in_valid)
        out_data <= cand_out;
    end
  end

endmodule

// File: tb/tb_intt_sdf_stage.sv
// tb/tb_intt_sdf_stage.sv - directed self-checking bench for intt_sdf_stage (D=1 and D=4 instances)
module tb_intt_sdf_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        v1, v4;
  logic [31:0] d1_in, d4_in;
  logic [31:0] tw1, tw4;
  logic [2:0]  a1, a4;
  logic        o1_valid, o4_valid;
  logic [31:0] o1_data, o4_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Inverse-twiddle ROM model for the D=4 stage: entry i holds 2*i+1
  assign tw4 = 32'(2 * a4 + 1);

  intt_sdf_stage #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1_in), .tw_addr(a1),
    .tw_data(tw1), .out_valid(o1_valid), .out_data(o1_data)
  );

  intt_sdf_stage #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4_in), .tw_addr(a4),
    .tw_data(tw4), .out_valid(o4_valid), .out_data(o4_data)
  );

  function automatic logic [31:0] sc(input longint unsigned v);
`ifdef INTT_SCALE_EN
    return 32'((v * 64'd6721) % 64'd7681);
`else
    return 32'(v);
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step1(input logic v, input logic [31:0] d);
    v1 = v; d1_in = d;
    @(posedge clk); #1;
  endtask

  task automatic step4(input logic v, input logic [31:0] d);
    v4 = v; d4_in = d;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [31:0] x4  [16];
  logic [2:0]  ea4 [16];
  logic        ev4 [16];
  logic [31:0] ed4 [16];

  initial begin
    x4  = '{1, 2, 3, 4, 10, 20, 30, 40, 0, 0, 0, 0, 0, 0, 0, 0};
    ea4 = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 0, 0, 0, 0, 0, 0, 0};
    ev4 = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    ed4 = '{0, 0, 0, 0, 11, 102, 273, 524, 7672, 7583, 7414, 7165, 0, 0, 0, 0};

    rst = 1'b1; v1 = 1'b1; v4 = 1'b1; d1_in = 32'd9; d4_in = 32'd9; tw1 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_o1_valid", {31'd0, o1_valid}, 32'd0);
      check_eq("rst_o1_data", o1_data, 32'd0);
      check_eq("rst_a1", {29'd0, a1}, 32'd0);
      check_eq("rst_o4_valid", {31'd0, o4_valid}, 32'd0);
      check_eq("rst_o4_data", o4_data, 32'd0);
      check_eq("rst_a4", {29'd0, a4}, 32'd0);
    end
    rst = 1'b0; v4 = 1'b0;

    // D=1 basic butterfly: 5,3,0 -> (none), 8, 2
    step1(1'b1, 32'd5);
    check_eq("basic_first_valid", {31'd0, o1_valid}, 32'd0);
    step1(1'b1, 32'd3);
    check_eq("basic_sum_valid", {31'd0, o1_valid}, 32'd1);
    check_eq("basic_sum", o1_data, sc(8));
    step1(1'b1, 32'd0);
    check_eq("basic_diff_valid", {31'd0, o1_valid}, 32'd1);
    check_eq("basic_diff", o1_data, sc(2));
    step1(1'b0, 32'd77);
    check_eq("stall1_valid", {31'd0, o1_valid}, 32'd0);
    check_eq("stall1_hold", o1_data, sc(2));

    // Underflow: 1,5,0 -> 6, 7677
    pulse_reset();
    step1(1'b1, 32'd1);
    step1(1'b1, 32'd5);
    check_eq("uflow_sum", o1_data, sc(6));
    step1(1'b1, 32'd0);
    check_eq("uflow_diff", o1_data, sc(7677));

    // Modular multiply with tw=q-1: 10,20,0 -> 7671, 30
    pulse_reset();
    tw1 = 32'd7680;
    step1(1'b1, 32'd10);
    step1(1'b1, 32'd20);
    check_eq("mul_sum", o1_data, sc(7671));
    step1(1'b1, 32'd0);
    check_eq("mul_diff", o1_data, sc(30));

    // Scaling vector: 8,0,0 -> 8, 8 unscaled (1, 1 with scaling)
    pulse_reset();
    tw1 = 32'd1;
    step1(1'b1, 32'd8);
    step1(1'b1, 32'd0);
    check_eq("scale_sum", o1_data, sc(8));
    step1(1'b1, 32'd0);
    check_eq("scale_diff", o1_data, sc(8));

    // Reset mid-block: next sample restarts at phase 0 with primed cleared
    pulse_reset();
    step1(1'b1, 32'd5);
    pulse_reset();
    check_eq("midrst_valid", {31'd0, o1_valid}, 32'd0);
    step1(1'b1, 32'd3);
    check_eq("midrst_first_valid", {31'd0, o1_valid}, 32'd0);
    step1(1'b1, 32'd4);
    check_eq("midrst_sum_valid", {31'd0, o1_valid}, 32'd1);
    check_eq("midrst_sum", o1_data, sc(7));
    v1 = 1'b0;

    // D=4 block, stall after the 5th sample, then flush with zeros
    pulse_reset();
    for (int k = 0; k < 12; k++) begin
      check_eq($sformatf("d4_addr_%0d", k), {29'd0, a4}, {29'd0, ea4[k]});
      step4(1'b1, x4[k]);
      check_eq($sformatf("d4_valid_%0d", k), {31'd0, o4_valid}, {31'd0, ev4[k]});
      if (ev4[k])
        check_eq($sformatf("d4_data_%0d", k), o4_data, sc(ed4[k]));
      if (k == 4) begin
        for (int s = 0; s < 3; s++) begin
          step4(1'b0, 32'd99);
          check_eq("d4_stall_valid", {31'd0, o4_valid}, 32'd0);
          check_eq("d4_stall_data", o4_data, sc(11));
          check_eq("d4_stall_addr", {29'd0, a4}, 32'd2);
        end
      end
    end
    step4(1'b0, 32'd0);
    check_eq("d4_idle_valid", {31'd0, o4_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
